// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package wb_arbiter_pkg;

  localparam int REG_W    = 5;
  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int CNT_W    = 6;

  localparam logic [CNT_W:0] CNT_MAX = 7'd32;

  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_FIFO,
    SRC_MEM,
    SRC_AMO
  } src_e;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] rd_mask(
    input logic [REG_W-1:0] rd,
    input logic             en
  );
    rd_mask = '0;
    if (en && rd != '0) rd_mask[rd] = 1'b1;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Issue, result and register-file port bundle of the writeback arbiter.
interface wb_arbiter_if;
  import wb_arbiter_pkg::*;

  logic             issue_valid;
  logic             issue_long;
  logic [REG_W-1:0] issue_rd;
  logic [REG_W-1:0] issue_rs1;
  logic [REG_W-1:0] issue_rs2;
  logic             issue_stall;

  logic             alu_valid;
  logic [REG_W-1:0] alu_rd;
  logic [XLEN-1:0]  alu_data;

  logic             mem_valid;
  logic [REG_W-1:0] mem_rd;
  logic [XLEN-1:0]  mem_data;
  logic             mem_ready;

  logic             amo_valid;
  logic [REG_W-1:0] amo_rd;
  logic [XLEN-1:0]  amo_data;
  logic             amo_ready;

  logic             write_enable;
  logic [REG_W-1:0] rd;
  logic [XLEN-1:0]  write_data;

  logic             atomic_write_enable;
  logic [REG_W-1:0] atomic_rd;
  logic [XLEN-1:0]  atomic_write_data;

  logic [NUM_REGS-1:0] busy;
  logic                idle;

  modport slave (
    input  issue_valid, issue_long, issue_rd,
    input  issue_rs1, issue_rs2,
    output issue_stall,
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    output mem_ready,
    input  amo_valid, amo_rd, amo_data,
    output amo_ready,
    output write_enable, rd, write_data,
    output atomic_write_enable, atomic_rd,
    output atomic_write_data,
    output busy, idle
  );

  modport master (
    output issue_valid, issue_long, issue_rd,
    output issue_rs1, issue_rs2,
    input  issue_stall,
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    input  mem_ready,
    output amo_valid, amo_rd, amo_data,
    input  amo_ready,
    input  write_enable, rd, write_data,
    input  atomic_write_enable, atomic_rd,
    input  atomic_write_data,
    input  busy, idle
  );

endinterface

// File: rtl/wb_fifo.sv
// Load-result skid FIFO: entries carry rd and data, order preserved.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  wb_entry_t              i_entry,
  input  logic                   i_pop,
  output wb_entry_t              o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  wb_entry_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [AW:0]     r_count;
  logic            w_pop;
  logic            w_push;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];

  // A push at full is only taken when the head leaves the same cycle.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_entry;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: main/atomic register-file ports, load skid FIFO,
// busy scoreboard and outstanding long-op counter.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  wb_arbiter_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                r_live;
  logic [NUM_REGS-1:0] r_busy;
  logic [CNT_W-1:0]    r_cnt;

  wb_entry_t           w_head;
  wb_entry_t           w_mem_entry;
  wb_entry_t           w_main;
  logic                w_full;
  logic                w_empty;
  logic [CW-1:0]       w_count;

  logic                w_alu_go;
  logic                w_pop;
  logic                w_mem_ready;
  logic                w_mem_acc;
  logic                w_bypass;
  logic                w_push;
  src_e                w_src;
  logic                w_main_act;
  logic                w_ld_commit;
  logic                w_amo_block;
  logic                w_amo_acc;

  logic [NUM_REGS-1:0] w_clr;
  logic [NUM_REGS-1:0] w_eff;
  logic [NUM_REGS-1:0] w_set;
  logic                w_issue_acc;
  logic                w_inc;

  logic [1:0]          w_dec;
  logic [CNT_W:0]      w_cnt_up;
  logic [CNT_W:0]      w_cnt_dn;
  logic [CNT_W-1:0]    w_cnt_nxt;

  // r_live masks every commit until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_live <= 1'b0;
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_live <= 1'b1;
      r_busy <= w_eff | w_set;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign w_mem_entry = '{rd: bus.mem_rd, data: bus.mem_data};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_entry (w_mem_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_alu_go    = r_live && bus.alu_valid;
  assign w_pop       = r_live && !bus.alu_valid && !w_empty;
  assign w_mem_ready = !w_full || w_pop;
  assign w_mem_acc   = r_live && bus.mem_valid && w_mem_ready;
  assign w_bypass    = w_mem_acc && !bus.alu_valid && w_empty;
  assign w_push      = w_mem_acc && !w_bypass;

  always_comb begin
    w_src  = SRC_NONE;
    w_main = '0;
    unique case (1'b1)
      w_alu_go: begin
        w_src  = SRC_ALU;
        w_main = '{rd: bus.alu_rd, data: bus.alu_data};
      end
      w_pop: begin
        w_src  = SRC_FIFO;
        w_main = w_head;
      end
      w_bypass: begin
        w_src  = SRC_MEM;
        w_main = w_mem_entry;
      end
      default: ;
    endcase
  end

  assign w_main_act  = (w_src != SRC_NONE);
  assign w_ld_commit = (w_src == SRC_FIFO) || (w_src == SRC_MEM);

  // An atomic result never races a main-port write to the same rd.
  assign w_amo_block = w_main_act && bus.amo_rd != '0
                    && w_main.rd == bus.amo_rd;
  assign w_amo_acc   = r_live && bus.amo_valid && !w_amo_block;

  assign bus.mem_ready  = w_mem_ready;
  assign bus.amo_ready  = !w_amo_block;

  assign bus.write_enable = w_main_act && w_main.rd != '0;
  assign bus.rd           = w_main.rd;
  assign bus.write_data   = w_main.data;

  assign bus.atomic_write_enable = w_amo_acc && bus.amo_rd != '0;
  assign bus.atomic_rd           = bus.amo_rd;
  assign bus.atomic_write_data   = bus.amo_data;

  assign w_clr = rd_mask(w_main.rd, w_ld_commit)
               | rd_mask(bus.amo_rd, w_amo_acc);
  assign w_eff = r_busy & ~w_clr;

  assign bus.issue_stall = bus.issue_valid
                        && (w_eff[bus.issue_rs1]
                         || w_eff[bus.issue_rs2]
                         || w_eff[bus.issue_rd]);

  assign w_issue_acc = r_live && bus.issue_valid && !bus.issue_stall;
  assign w_inc       = w_issue_acc && bus.issue_long;
  assign w_set       = rd_mask(bus.issue_rd, w_inc);

  always_comb begin
    w_dec     = {1'b0, w_ld_commit} + {1'b0, w_amo_acc};
    w_cnt_up  = {1'b0, r_cnt} + {{CNT_W{1'b0}}, w_inc};
    w_cnt_dn  = w_cnt_up - {{(CNT_W-1){1'b0}}, w_dec};
    w_cnt_nxt = w_cnt_dn[CNT_W-1:0];
    if (w_cnt_up < {{(CNT_W-1){1'b0}}, w_dec})
      w_cnt_nxt = '0;
    else if (w_cnt_dn > CNT_MAX)
      w_cnt_nxt = CNT_MAX[CNT_W-1:0];
  end

  assign bus.busy = r_busy;
  assign bus.idle = (r_cnt == '0) && (w_count == '0);

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int D = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if bus();

  wb_arbiter #(.FIFO_DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic        iv, il, av, mv, ov;
  logic [4:0]  ird, rs1, rs2, ard, mrd, ord;
  logic [31:0] ad, md, od;

  wb_entry_t m_fifo[$];
  bit        m_busy[32];
  int        m_cnt;
  wb_entry_t exp_main[$];
  wb_entry_t exp_amo[$];
  wb_entry_t mon_e;

  bit          m_mem_acc, m_amo_acc, m_iss_acc;
  logic        d_we, d_awe, d_stall, d_amo_rdy, d_mem_rdy;
  logic [4:0]  d_rd, d_ard;
  logic [31:0] d_wd;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic clear_stim();
    iv = 0; il = 0; ird = 0; rs1 = 0; rs2 = 0;
    av = 0; ard = 0; ad = 0;
    mv = 0; mrd = 0; md = 0;
    ov = 0; ord = 0; od = 0;
  endtask

  task automatic drive();
    bus.issue_valid = iv;  bus.issue_long = il;
    bus.issue_rd = ird;    bus.issue_rs1 = rs1;
    bus.issue_rs2 = rs2;
    bus.alu_valid = av;    bus.alu_rd = ard;
    bus.alu_data = ad;
    bus.mem_valid = mv;    bus.mem_rd = mrd;
    bus.mem_data = md;
    bus.amo_valid = ov;    bus.amo_rd = ord;
    bus.amo_data = od;
  endtask

  task automatic model_reset();
    m_fifo.delete();
    exp_main.delete();
    exp_amo.delete();
    foreach (m_busy[i]) m_busy[i] = 0;
    m_cnt = 0;
  endtask

  function automatic logic [31:0] busy_vec();
    logic [31:0] v;
    foreach (m_busy[i]) v[i] = m_busy[i];
    return v;
  endfunction

  // One clock of stimulus: predict, compare handshakes, queue writes.
  task automatic step();
    bit pop, mrdy, macc, byp, has_main, ld, ardy, aacc;
    bit stall, iacc;
    bit clr[32];
    wb_entry_t mw;
    drive();
    #1;
    pop  = !av && m_fifo.size() > 0;
    mrdy = m_fifo.size() < D || pop;
    macc = mv && mrdy;
    byp  = macc && !av && m_fifo.size() == 0;
    has_main = 1;
    ld = 1;
    if (av) begin
      mw = '{rd: ard, data: ad};
      ld = 0;
    end else if (pop) mw = m_fifo[0];
    else if (macc) mw = '{rd: mrd, data: md};
    else begin
      has_main = 0;
      ld = 0;
      mw = '0;
    end
    ardy = !(has_main && ord != 0 && mw.rd == ord);
    aacc = ov && ardy;
    foreach (clr[i]) clr[i] = 0;
    if (ld && mw.rd != 0) clr[mw.rd] = 1;
    if (aacc && ord != 0) clr[ord] = 1;
    stall = iv && ((m_busy[rs1] && !clr[rs1])
                || (m_busy[rs2] && !clr[rs2])
                || (m_busy[ird] && !clr[ird]));
    iacc = iv && !stall;
    chk("mem_ready", bus.mem_ready, mrdy);
    chk("amo_ready", bus.amo_ready, ardy);
    chk("issue_stall", bus.issue_stall, stall);
    if (has_main && mw.rd != 0) exp_main.push_back(mw);
    if (aacc && ord != 0) exp_amo.push_back('{rd: ord, data: od});
    d_we = bus.write_enable;   d_rd = bus.rd;
    d_wd = bus.write_data;     d_awe = bus.atomic_write_enable;
    d_ard = bus.atomic_rd;     d_stall = bus.issue_stall;
    d_amo_rdy = bus.amo_ready; d_mem_rdy = bus.mem_ready;
    m_mem_acc = macc; m_amo_acc = aacc; m_iss_acc = iacc;
    @(posedge clk);
    if (pop) void'(m_fifo.pop_front());
    if (macc && !byp) m_fifo.push_back('{rd: mrd, data: md});
    foreach (clr[i]) if (clr[i]) m_busy[i] = 0;
    if (iacc && il && ird != 0) m_busy[ird] = 1;
    m_cnt = m_cnt + int'(iacc && il) - int'(ld) - int'(aacc);
    if (m_cnt < 0) m_cnt = 0;
    if (m_cnt > 32) m_cnt = 32;
    #1;
    chk("busy", bus.busy, busy_vec());
    chk("idle", bus.idle, (m_cnt == 0 && m_fifo.size() == 0));
  endtask

  always @(negedge clk) begin
    if (bus.write_enable === 1'b1) begin
      if (exp_main.size() == 0) begin
        checks++; errors++;
        $display("FAIL main_write unexpected rd=%0d", bus.rd);
      end else begin
        mon_e = exp_main.pop_front();
        chk("main_rd", bus.rd, mon_e.rd);
        chk("main_data", bus.write_data, mon_e.data);
      end
    end else if (exp_main.size() != 0) begin
      checks++; errors++;
      $display("FAIL main_write missing: got none expected rd=%0d",
               exp_main[0].rd);
      void'(exp_main.pop_front());
    end
    if (bus.atomic_write_enable === 1'b1) begin
      if (exp_amo.size() == 0) begin
        checks++; errors++;
        $display("FAIL amo_write unexpected rd=%0d", bus.atomic_rd);
      end else begin
        mon_e = exp_amo.pop_front();
        chk("amo_rd", bus.atomic_rd, mon_e.rd);
        chk("amo_data", bus.atomic_write_data, mon_e.data);
      end
    end else if (exp_amo.size() != 0) begin
      checks++; errors++;
      $display("FAIL amo_write missing: got none expected rd=%0d",
               exp_amo[0].rd);
      void'(exp_amo.pop_front());
    end
  end

  initial begin
    int idx;
    int outq[$];
    clear_stim();
    drive();
    model_reset();
    #1;
    chk("rst_mem_ready", bus.mem_ready, 1);
    chk("rst_amo_ready", bus.amo_ready, 1);
    chk("rst_idle", bus.idle, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_we", bus.write_enable, 0);
    chk("rst_awe", bus.atomic_write_enable, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;

    clear_stim(); iv = 1; il = 1; ird = 5;
    step();
    clear_stim(); mv = 1; mrd = 5; md = 32'hA5;
    step();
    chk("r031_we", d_we, 1);
    chk("r031_rd", d_rd, 5);
    chk("r031_data", d_wd, 32'hA5);
    chk("r031_busy5", bus.busy[5], 0);

    idx = 0;
    for (int c = 0; c < 8; c++) begin
      clear_stim();
      av = (c < 3); ard = 1; ad = c;
      if (idx < 3) begin
        mv = 1; mrd = 5'(7 + idx); md = 100 + idx;
      end
      step();
      if (c == 2) chk("r032_ready_full", d_mem_rdy, 0);
      if (c >= 3 && c <= 5) chk("r032_order", d_rd, 7 + c - 3);
      if (m_mem_acc) idx++;
    end

    clear_stim(); av = 1; ard = 4; ad = 32'h44;
    ov = 1; ord = 4; od = 32'h99;
    step();
    chk("r033_amo_ready", d_amo_rdy, 0);
    chk("r033_awe_blocked", d_awe, 0);
    chk("r033_alu_we", d_we, 1);
    clear_stim(); ov = 1; ord = 4; od = 32'h99;
    step();
    chk("r033_awe", d_awe, 1);
    chk("r033_ard", d_ard, 4);

    clear_stim(); iv = 1; il = 1; ird = 3;
    step();
    clear_stim(); iv = 1; ird = 10; rs1 = 3;
    step();
    chk("r034_stall_early", d_stall, 1);
    clear_stim(); iv = 1; ird = 10; rs1 = 3;
    ov = 1; ord = 3; od = 32'h33;
    step();
    chk("r034_stall_fwd", d_stall, 0);

    clear_stim(); iv = 1; il = 1; ird = 0;
    step();
    chk("r035_not_idle", bus.idle, 0);
    clear_stim(); mv = 1; mrd = 0; md = 1;
    step();
    chk("r035_we", d_we, 0);
    chk("r035_busy", bus.busy, 0);
    chk("r035_idle", bus.idle, 1);

    clear_stim();
    for (int c = 0; c < 400; c++) begin
      iv  = ($urandom_range(0, 2) == 0);
      il  = 1'($urandom_range(0, 1));
      ird = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      av  = ($urandom_range(0, 9) < 4);
      ard = 5'($urandom_range(0, 7));
      ad  = $urandom;
      if (!mv && outq.size() > 0 && $urandom_range(0, 2) == 0) begin
        mv = 1; mrd = 5'(outq.pop_front()); md = $urandom;
      end
      if (!ov && outq.size() > 0 && $urandom_range(0, 2) == 0) begin
        ov = 1; ord = 5'(outq.pop_front()); od = $urandom;
      end
      step();
      if (m_iss_acc && il) outq.push_back(int'(ird));
      if (m_mem_acc) mv = 0;
      if (m_amo_acc) ov = 0;
    end

    clear_stim(); iv = 1; il = 1; ird = 11;
    step();
    clear_stim(); av = 1; ard = 2; mv = 1; mrd = 11; md = 32'hB1;
    step();
    clear_stim(); av = 1; ard = 2; mv = 1; mrd = 12; md = 32'hB2;
    step();
    clear_stim();
    drive();
    reset = 1'b0;
    #1;
    chk("r036_mem_ready", bus.mem_ready, 1);
    chk("r036_idle", bus.idle, 1);
    chk("r036_busy", bus.busy, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) step();

    chk("exp_main_drained", exp_main.size(), 0);
    chk("exp_amo_drained", exp_amo.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
